i2c_nco_regbank: RTL and testbench
==================================

Name: i2c_nco_regbank

Overview:
- Parametrised I2C slave register bank configuring NUM_CH NCO channels: per channel enable, waveform, frequency word and duty-cycle word.
- Successor to the single-channel NCO I2C slave. Adds a register pointer with auto-increment, read-back over repeated START, multi-channel addressing, and atomic commit on STOP.
- The commit rule means an NCO never sees a partially written frequency word.
- Sits between the board I2C pins (through the top-level open-drain pad) and the NCO channel array.

Parameters:
- ADDRESS, 7'b1101010: 7-bit slave address.
- NUM_CH, 4: number of NCO channels (1..16).
- FREQ_BYTES, 8: frequency word width in bytes (1..8).
- DUTY_BYTES, 2: duty-cycle word width in bytes (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scl  in  1  I2C clock from pad (asynchronous).
- sda_i  in  1  I2C data from pad (asynchronous).
- sda_oe  out  1  1 = pull SDA low; the pad is open-drain.
- frequency  out  NUM_CH*FREQ_BYTES*8  live frequency words; channel c at bits [c*FREQ_BYTES*8 +: FREQ_BYTES*8].
- duty_cycle  out  NUM_CH*DUTY_BYTES*8  live duty words, same packing.
- wave  out  NUM_CH*2  live waveform select.
- enable  out  NUM_CH  live channel enable.
- update  out  NUM_CH  one-cycle commit pulse per channel.
- busy  out  1  high from START until STOP.

Behaviour:
- Synchronisation and edges:
  - scl and sda_i each pass through a 2-FF synchroniser plus one history FF.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high. Both use the synchronised signals.
  - Bits are sampled on the synchronised SCL rising edge. sda_oe changes only on the synchronised SCL falling edge.
  - SCL high and low phases are each at least 4 clk cycles.
- Register map:
  - STRIDE = 1+FREQ_BYTES+DUTY_BYTES. Register index = ch*STRIDE + offset. Total = NUM_CH*STRIDE.
  - Offset 0 is CTRL: bit0 = enable, bits2:1 = wave, bits7:3 read 0.
  - Offsets 1..FREQ_BYTES hold frequency, MSB first.
  - The next DUTY_BYTES offsets hold duty, MSB first.
- State machine: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
  - START from any state goes to ADDR, clears the bit counter and sets busy. A repeated START keeps the pointer and the shadow/dirty state.
  - ADDR: shift 8 bits. If address matches, go to ADDR_ACK and drive ACK for one SCL period.
    - R/W=0 then goes to PTR.
    - R/W=1 loads the read byte from the live register at the pointer and goes to RD.
    - Mismatch goes to WAIT_STOP with no ACK.
  - PTR: the first write byte sets the pointer.
    - If < Total: ACK, then go to WR.
    - Otherwise: NACK, then go to WAIT_STOP.
  - WR: each byte is written to the shadow register at the pointer and marks the channel dirty, then pointer+1.
    - ACK if the pointer was < Total. Otherwise NACK, no write, go to WAIT_STOP.
  - RD: drive 8 bits MSB first. The pointer advances after each byte. Out-of-range reads return 0xFF.
    - RD_ACK samples the master's bit: ACK goes back to RD with the next byte; NACK goes to WAIT_STOP.
  - There is no pointer wrap-around.
- Commit on STOP:
  - One clk after STOP detect: every dirty channel copies its whole shadow to the live outputs, update[c] pulses for exactly 1 cycle, dirty clears, busy=0, state goes to IDLE.
  - A STOP after a NACK still commits bytes that were already ACKed.
  - A repeated START does not commit.
- Shadow behaviour:
  - Shadows always hold the last written value; unwritten bytes keep their prior shadow value.
  - Reads return the live registers.
- Reset:
  - All outputs, shadows, dirty flags, pointer and update are 0. sda_oe=0, busy=0, state IDLE.
  - Reset mid-transaction aborts it with no commit. The bus is ignored until the next START.

Test Plan:
- Write-and-commit, channel 0: START, 0xD4, ptr 0x00, CTRL 0x03, freq 01 05 70 EB 13 45 23 A0, duty 1F 40, STOP -> every byte ACKed; only after STOP: frequency[63:0]=0x010570EB134523A0, duty_cycle[15:0]=0x1F40, wave[1:0]=01, enable[0]=1, update=0001 for one cycle.
- Channel 2 duty only: ptr 2*11+9=31, bytes 12 34, STOP -> duty ch2=0x1234; ch2 freq unchanged; update=0100; ch0 untouched.
- Atomicity: write 4 freq bytes to ch1 and hold before STOP -> frequency ch1 remains 0 until STOP, then the upper 4 bytes update.
- Read-back: after the first test, START, 0xD4, ptr 0x01, repeated START, 0xD5, read 3 bytes with ACK, ACK, NACK, STOP -> 0x01, 0x05, 0x70; no update pulse.
- Errors: address 0xA0 -> no ACK, outputs unchanged. Ptr 44 (=Total) -> NACK. Writing past index 43 -> NACK for that byte, earlier bytes committed.
- Reset asserted mid-frequency write -> all outputs 0, no update; the next full transaction behaves as in the first test.

Source files
------------

// File: rtl/i2c_nco_regbank.sv
// i2c_nco_regbank: I2C slave register bank for NUM_CH NCO channels with auto-increment pointer and atomic commit on STOP
module i2c_nco_regbank #(
  parameter logic [6:0] ADDRESS    = 7'b1101010,
  parameter int         NUM_CH     = 4,
  parameter int         FREQ_BYTES = 8,
  parameter int         DUTY_BYTES = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             scl,
  input  logic                             sda_i,
  output logic                             sda_oe,
  output logic [NUM_CH*FREQ_BYTES*8-1:0]   frequency,
  output logic [NUM_CH*DUTY_BYTES*8-1:0]   duty_cycle,
  output logic [NUM_CH*2-1:0]              wave,
  output logic [NUM_CH-1:0]                enable,
  output logic [NUM_CH-1:0]                update,
  output logic                             busy
);
  localparam int STRIDE = 1 + FREQ_BYTES + DUTY_BYTES;
  localparam int TOTAL = NUM_CH * STRIDE;
  localparam int IW = $clog2(TOTAL);
  localparam logic [7:0] TOT8 = 8'(TOTAL);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP} state_t;
  state_t state;
  logic [2:0] scl_s, sda_s, bit_cnt;
  logic [6:0] shift_q;
  logic [7:0] ptr, rd_byte, rx_byte, rd_val, ptr_next;
  logic [7:0] shadow [TOTAL];
  logic [7:0] live [TOTAL];
  logic [TOTAL-1:0] dirty;
  logic [NUM_CH-1:0] ch_dirty;
  logic rw, phase, commit, sda_bit, in_range, last;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign start_det = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
  assign stop_det = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];
  assign sda_bit = sda_s[1];
  assign rx_byte = {shift_q, sda_bit};
  assign last = bit_cnt == 3'd7;
  assign in_range = ptr < TOT8;
  assign rd_val = in_range ? live[ptr[IW-1:0]] : 8'hff;
  assign ptr_next = in_range ? ptr + 8'd1 : ptr;
  always_comb begin
    ch_dirty = '0;
    for (int c = 0; c < NUM_CH; c++) ch_dirty[c] = |dirty[c*STRIDE +: STRIDE];
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign enable[c] = live[c*STRIDE][0];
    assign wave[c*2 +: 2] = live[c*STRIDE][2:1];
    for (genvar k = 0; k < FREQ_BYTES; k++) begin : g_f
      assign frequency[(c*FREQ_BYTES + FREQ_BYTES-1-k)*8 +: 8] = live[c*STRIDE+1+k];
    end
    for (genvar k = 0; k < DUTY_BYTES; k++) begin : g_d
      assign duty_cycle[(c*DUTY_BYTES + DUTY_BYTES-1-k)*8 +: 8] = live[c*STRIDE+1+FREQ_BYTES+k];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s <= '1;
      sda_s <= '1;
      state <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      ptr <= '0;
      rd_byte <= '0;
      rw <= 1'b0;
      phase <= 1'b0;
      commit <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      update <= '0;
      dirty <= '0;
      for (int i = 0; i < TOTAL; i++) begin
        shadow[i] <= '0;
        live[i] <= '0;
      end
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda_i};
      commit <= stop_det;
      update <= commit ? ch_dirty : '0;
      if (commit) begin
        dirty <= '0;
        for (int c = 0; c < NUM_CH; c++)
          for (int k = 0; k < STRIDE; k++)
            if (ch_dirty[c]) live[c*STRIDE+k] <= (k == 0) ? shadow[c*STRIDE+k] & 8'h07 : shadow[c*STRIDE+k];
      end
      if (start_det) begin
        state <= ADDR;
        bit_cnt <= '0;
        phase <= 1'b0;
        busy <= 1'b1;
      end else if (stop_det) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (scl_rise) begin
        if (state inside {ADDR, PTR, WR, RD}) begin
          shift_q <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          phase <= 1'b0;
        end
        case (state)
          ADDR: if (last) begin
            rw <= sda_bit;
            rd_byte <= rd_val;
            state <= (rx_byte[7:1] == ADDRESS) ? ADDR_ACK : WAIT_STOP;
          end
          PTR: if (last) begin
            ptr <= rx_byte;
            state <= (rx_byte < TOT8) ? PTR_ACK : WAIT_STOP;
          end
          WR: if (last) begin
            if (in_range) begin
              shadow[ptr[IW-1:0]] <= rx_byte;
              dirty[ptr[IW-1:0]] <= 1'b1;
              ptr <= ptr_next;
            end
            state <= in_range ? WR_ACK : WAIT_STOP;
          end
          RD: if (last) begin
            ptr <= ptr_next;
            state <= RD_ACK;
          end
          RD_ACK: if (sda_bit) state <= WAIT_STOP;
          else begin
            rd_byte <= rd_val;
            phase <= 1'b1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, WR_ACK: if (!phase) begin
            sda_oe <= 1'b1;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            sda_oe <= (state == ADDR_ACK && rw) ? ~rd_byte[7] : 1'b0;
            state <= (state == ADDR_ACK) ? (rw ? RD : PTR) : WR;
          end
          RD: sda_oe <= ~rd_byte[~bit_cnt];
          RD_ACK: begin
            sda_oe <= phase ? ~rd_byte[7] : 1'b0;
            if (phase) begin
              state <= RD;
              phase <= 1'b0;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_nco_regbank.sv
// tb_i2c_nco_regbank: directed bit-banged I2C master checking writes, commit, read-back, errors and reset
module tb_i2c_nco_regbank;
  localparam int Q = 50;
  logic clk = 0, reset = 1, scl = 1, sda_m = 1;
  logic sda_oe, sda_line, busy;
  logic [255:0] frequency;
  logic [63:0] duty_cycle;
  logic [7:0] wave;
  logic [3:0] enable, update;
  logic [3:0] upd_prev = '0;
  logic upd_long = 0;
  int upd_cnt [4];
  int pass_cnt = 0, total_cnt = 0;
  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_nco_regbank dut (
    .clk(clk), .reset(reset), .scl(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .frequency(frequency), .duty_cycle(duty_cycle), .wave(wave), .enable(enable),
    .update(update), .busy(busy)
  );
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) if (update[c]) upd_cnt[c]++;
    if (|(update & upd_prev)) upd_long = 1;
    upd_prev = update;
  end
  task automatic clr_upd();
    for (int c = 0; c < 4; c++) upd_cnt[c] = 0;
  endtask
  task automatic i2c_start();
    sda_m = 1; #Q; scl = 1; #Q; sda_m = 0; #Q; scl = 0; #Q;
  endtask
  task automatic i2c_stop();
    sda_m = 0; #Q; scl = 1; #Q; sda_m = 1; #(2*Q);
  endtask
  task automatic i2c_wr(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl = 1; #(2*Q); scl = 0; #Q;
    end
    sda_m = 1; #Q; scl = 1; #Q; ack = ~sda_line; #Q; scl = 0; #Q;
  endtask
  task automatic i2c_rd(input logic ack_m, output logic [7:0] b);
    sda_m = 1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1; #Q; b[i] = sda_line; #Q; scl = 0;
    end
    #Q; sda_m = ~ack_m; #Q; scl = 1; #(2*Q); scl = 0; #Q; sda_m = 1;
  endtask
  task automatic full_write();
    logic [7:0] seq [13] = '{8'hD4, 8'h00, 8'h03, 8'h01, 8'h05, 8'h70, 8'hEB, 8'h13, 8'h45, 8'h23, 8'hA0, 8'h1F, 8'h40};
    logic ack, all_ack;
    clr_upd();
    all_ack = 1;
    i2c_start();
    for (int i = 0; i < 13; i++) begin
      i2c_wr(seq[i], ack);
      all_ack &= ack;
    end
    total_cnt++; if (all_ack !== 1'b1) $display("FAIL wc_acks got=%b exp=1", all_ack); else pass_cnt++;
    total_cnt++; if (frequency[63:0] !== 64'h0) $display("FAIL wc_precommit got=%h exp=0", frequency[63:0]); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL wc_busy got=%b exp=1", busy); else pass_cnt++;
    total_cnt++; if (upd_cnt[0] !== 0) $display("FAIL wc_early_update got=%0d exp=0", upd_cnt[0]); else pass_cnt++;
    i2c_stop();
    total_cnt++; if (frequency[63:0] !== 64'h010570EB134523A0) $display("FAIL wc_freq got=%h exp=010570eb134523a0", frequency[63:0]); else pass_cnt++;
    total_cnt++; if (duty_cycle[15:0] !== 16'h1F40) $display("FAIL wc_duty got=%h exp=1f40", duty_cycle[15:0]); else pass_cnt++;
    total_cnt++; if ({wave[1:0], enable[0]} !== 3'b011) $display("FAIL wc_ctrl got=%b exp=011", {wave[1:0], enable[0]}); else pass_cnt++;
    total_cnt++; if ({upd_cnt[3], upd_cnt[2], upd_cnt[1], upd_cnt[0]} !== {32'd0, 32'd0, 32'd0, 32'd1}) $display("FAIL wc_update got=%0d%0d%0d%0d exp=0001", upd_cnt[3], upd_cnt[2], upd_cnt[1], upd_cnt[0]); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL wc_idle got=%b exp=0", busy); else pass_cnt++;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    total_cnt++; if (frequency !== '0) $display("FAIL rst_freq got=%h exp=0", frequency); else pass_cnt++;
    total_cnt++; if (duty_cycle !== '0) $display("FAIL rst_duty got=%h exp=0", duty_cycle); else pass_cnt++;
    total_cnt++; if (wave !== '0) $display("FAIL rst_wave got=%h exp=0", wave); else pass_cnt++;
    total_cnt++; if (enable !== '0) $display("FAIL rst_enable got=%h exp=0", enable); else pass_cnt++;
    total_cnt++; if (update !== '0) $display("FAIL rst_update got=%h exp=0", update); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); else pass_cnt++;
  endtask
  task automatic test_ch2_duty();
    logic a0, a1, a2, a3;
    clr_upd();
    i2c_start(); i2c_wr(8'hD4, a0); i2c_wr(8'd31, a1); i2c_wr(8'h12, a2); i2c_wr(8'h34, a3); i2c_stop();
    total_cnt++; if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL ch2_acks got=%b exp=1111", {a0, a1, a2, a3}); else pass_cnt++;
    total_cnt++; if (duty_cycle[32 +: 16] !== 16'h1234) $display("FAIL ch2_duty got=%h exp=1234", duty_cycle[32 +: 16]); else pass_cnt++;
    total_cnt++; if (frequency[128 +: 64] !== 64'h0) $display("FAIL ch2_freq got=%h exp=0", frequency[128 +: 64]); else pass_cnt++;
    total_cnt++; if ({upd_cnt[3], upd_cnt[2], upd_cnt[1], upd_cnt[0]} !== {32'd0, 32'd1, 32'd0, 32'd0}) $display("FAIL ch2_update got=%0d%0d%0d%0d exp=0100", upd_cnt[3], upd_cnt[2], upd_cnt[1], upd_cnt[0]); else pass_cnt++;
    total_cnt++; if (frequency[63:0] !== 64'h010570EB134523A0) $display("FAIL ch2_ch0_kept got=%h exp=010570eb134523a0", frequency[63:0]); else pass_cnt++;
  endtask
  task automatic test_atomic();
    logic [7:0] seq [6] = '{8'hD4, 8'd12, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic ack;
    clr_upd();
    i2c_start();
    for (int i = 0; i < 6; i++) i2c_wr(seq[i], ack);
    repeat (200) @(negedge clk);
    total_cnt++; if (frequency[64 +: 64] !== 64'h0) $display("FAIL at_hold_freq got=%h exp=0", frequency[64 +: 64]); else pass_cnt++;
    total_cnt++; if (upd_cnt[1] !== 0) $display("FAIL at_hold_update got=%0d exp=0", upd_cnt[1]); else pass_cnt++;
    i2c_stop();
    total_cnt++; if (frequency[64 +: 64] !== 64'hDEADBEEF00000000) $display("FAIL at_freq got=%h exp=deadbeef00000000", frequency[64 +: 64]); else pass_cnt++;
    total_cnt++; if (upd_cnt[1] !== 1) $display("FAIL at_update got=%0d exp=1", upd_cnt[1]); else pass_cnt++;
  endtask
  task automatic test_readback();
    logic a0, a1, a2;
    logic [7:0] b0, b1, b2;
    clr_upd();
    i2c_start(); i2c_wr(8'hD4, a0); i2c_wr(8'h01, a1);
    i2c_start(); i2c_wr(8'hD5, a2);
    i2c_rd(1'b1, b0); i2c_rd(1'b1, b1); i2c_rd(1'b0, b2);
    i2c_stop();
    total_cnt++; if ({a0, a1, a2} !== 3'b111) $display("FAIL rb_acks got=%b exp=111", {a0, a1, a2}); else pass_cnt++;
    total_cnt++; if (b0 !== 8'h01) $display("FAIL rb_byte0 got=%h exp=01", b0); else pass_cnt++;
    total_cnt++; if (b1 !== 8'h05) $display("FAIL rb_byte1 got=%h exp=05", b1); else pass_cnt++;
    total_cnt++; if (b2 !== 8'h70) $display("FAIL rb_byte2 got=%h exp=70", b2); else pass_cnt++;
    total_cnt++; if ((upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]) !== 0) $display("FAIL rb_update got=%0d exp=0", upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]); else pass_cnt++;
    total_cnt++; if (sda_oe !== 1'b0) $display("FAIL rb_release got=%b exp=0", sda_oe); else pass_cnt++;
  endtask
  task automatic test_errors();
    logic a0, a1, a2, a3, a4;
    clr_upd();
    i2c_start(); i2c_wr(8'hA0, a0); i2c_wr(8'h00, a1); i2c_stop();
    total_cnt++; if ({a0, a1} !== 2'b00) $display("FAIL er_badaddr_acks got=%b exp=00", {a0, a1}); else pass_cnt++;
    total_cnt++; if (frequency[63:0] !== 64'h010570EB134523A0) $display("FAIL er_badaddr_freq got=%h exp=010570eb134523a0", frequency[63:0]); else pass_cnt++;
    i2c_start(); i2c_wr(8'hD4, a0); i2c_wr(8'd44, a1); i2c_stop();
    total_cnt++; if ({a0, a1} !== 2'b10) $display("FAIL er_ptr44_acks got=%b exp=10", {a0, a1}); else pass_cnt++;
    total_cnt++; if ((upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]) !== 0) $display("FAIL er_noupdate got=%0d exp=0", upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]); else pass_cnt++;
    i2c_start(); i2c_wr(8'hD4, a0); i2c_wr(8'd42, a1); i2c_wr(8'hAB, a2); i2c_wr(8'hCD, a3); i2c_wr(8'hEF, a4); i2c_stop();
    total_cnt++; if ({a0, a1, a2, a3, a4} !== 5'b11110) $display("FAIL er_past_end_acks got=%b exp=11110", {a0, a1, a2, a3, a4}); else pass_cnt++;
    total_cnt++; if (duty_cycle[48 +: 16] !== 16'hABCD) $display("FAIL er_past_end_duty got=%h exp=abcd", duty_cycle[48 +: 16]); else pass_cnt++;
    total_cnt++; if ({upd_cnt[3], upd_cnt[2], upd_cnt[1], upd_cnt[0]} !== {32'd1, 32'd0, 32'd0, 32'd0}) $display("FAIL er_past_end_update got=%0d%0d%0d%0d exp=1000", upd_cnt[3], upd_cnt[2], upd_cnt[1], upd_cnt[0]); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    logic [7:0] seq [6] = '{8'hD4, 8'h00, 8'h03, 8'h01, 8'h05, 8'h70};
    logic ack;
    clr_upd();
    i2c_start();
    for (int i = 0; i < 6; i++) i2c_wr(seq[i], ack);
    @(negedge clk); reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    total_cnt++; if (frequency !== '0) $display("FAIL rm_freq got=%h exp=0", frequency); else pass_cnt++;
    total_cnt++; if (duty_cycle !== '0) $display("FAIL rm_duty got=%h exp=0", duty_cycle); else pass_cnt++;
    total_cnt++; if ({wave, enable} !== 12'h0) $display("FAIL rm_ctrl got=%h exp=0", {wave, enable}); else pass_cnt++;
    total_cnt++; if ({busy, sda_oe} !== 2'b00) $display("FAIL rm_bus got=%b exp=00", {busy, sda_oe}); else pass_cnt++;
    scl = 1; #Q; sda_m = 1; #(4*Q);
    total_cnt++; if ((upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]) !== 0) $display("FAIL rm_update got=%0d exp=0", upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]); else pass_cnt++;
    full_write();
  endtask
  initial begin
    test_reset();
    full_write();
    test_ch2_duty();
    test_atomic();
    test_readback();
    test_errors();
    test_reset_mid();
    total_cnt++; if (upd_long !== 1'b0) $display("FAIL update_width got=%b exp=0", upd_long); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
